// File: rtl/iob_dma_axis_packer.sv
// AXI-Stream width packer: gathers IN_W samples into OUT_W words for the DMA input,
// with flush and a packed-word counter. Define IOB_DMA_PACKER_TKEEP_EN to add out_tkeep_o.
module iob_dma_axis_packer #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int CNT_W = 32
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     rst_n_i,
    input  logic                     clr_i,
    input  logic                     flush_i,
    input  logic [IN_W-1:0]          in_tdata_i,
    input  logic                     in_tvalid_i,
    output logic                     in_tready_o,
    input  logic                     in_tlast_i,
    output logic [OUT_W-1:0]         out_tdata_o,
    output logic                     out_tvalid_o,
    input  logic                     out_tready_i,
    output logic                     out_tlast_o,
    output logic [CNT_W-1:0]         word_cnt_o
`ifdef IOB_DMA_PACKER_TKEEP_EN
    ,
    output logic [OUT_W/IN_W-1:0]    out_tkeep_o
`endif
);

    localparam int RATIO  = OUT_W / IN_W;
    localparam int LANE_W = $clog2(RATIO);

    logic [LANE_W-1:0] lane_q, lane_nxt;
    logic [OUT_W-1:0]  acc_q, acc_pk;
    logic [OUT_W-1:0]  out_data_q;
    logic              out_valid_q, out_last_q;
    logic              flush_pend_q, flush_pend_nxt;
    logic [CNT_W-1:0]  word_cnt_q;

    logic in_hs, out_hs, out_free, last_lane;
    logic load_in, load_fl, defer;

    assign last_lane    = (lane_q == LANE_W'(RATIO - 1));
    assign in_tready_o  = rst_n_i & cke_i & ~flush_pend_q
                        & ~(last_lane & out_valid_q & ~out_tready_i);
    assign out_tvalid_o = out_valid_q & cke_i;
    assign out_tdata_o  = out_data_q;
    assign out_tlast_o  = out_last_q;
    assign word_cnt_o   = word_cnt_q;

    assign in_hs    = in_tvalid_i & in_tready_o;
    assign out_hs   = out_tvalid_o & out_tready_i;
    assign out_free = ~out_valid_q | out_tready_i;

    // A tlast on a middle lane while the out register is stuck is parked as a
    // pending flush, so the input handshake never has to look at tlast.
    assign load_in = in_hs & (last_lane | in_tlast_i) & out_free;
    assign defer   = in_hs & in_tlast_i & ~last_lane & ~out_free;
    assign load_fl = flush_pend_q & out_free;

    always_comb begin
        acc_pk = acc_q;
        for (int k = 0; k < RATIO; k++)
            if (in_hs && lane_q == LANE_W'(k))
                acc_pk[k*IN_W +: IN_W] = in_tdata_i;
    end

    always_comb begin
        lane_nxt = lane_q;
        if (load_in || load_fl)
            lane_nxt = '0;
        else if (in_hs)
            lane_nxt = lane_q + LANE_W'(1);
    end

    always_comb begin
        flush_pend_nxt = flush_pend_q;
        if (load_fl)
            flush_pend_nxt = 1'b0;
        if ((flush_i || defer) && lane_nxt != '0)
            flush_pend_nxt = 1'b1;
    end

`ifdef IOB_DMA_PACKER_TKEEP_EN
    logic [RATIO-1:0] keep_q, keep_pk, keep_out_q;

    always_comb begin
        keep_pk = keep_q;
        for (int k = 0; k < RATIO; k++)
            if (in_hs && lane_q == LANE_W'(k))
                keep_pk[k] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            keep_q     <= '0;
            keep_out_q <= '0;
        end else if (cke_i) begin
            if (load_in) begin
                keep_out_q <= keep_pk;
                keep_q     <= '0;
            end else if (load_fl) begin
                keep_out_q <= keep_q;
                keep_q     <= '0;
            end else begin
                keep_q     <= keep_pk;
            end
        end
    end

    assign out_tkeep_o = keep_out_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lane_q       <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            word_cnt_q   <= '0;
        end else if (cke_i) begin
            lane_q       <= lane_nxt;
            flush_pend_q <= flush_pend_nxt;
            if (load_in) begin
                out_data_q  <= acc_pk;
                out_last_q  <= in_tlast_i;
                out_valid_q <= 1'b1;
                acc_q       <= '0;
            end else if (load_fl) begin
                out_data_q  <= acc_q;
                out_last_q  <= 1'b1;
                out_valid_q <= 1'b1;
                acc_q       <= '0;
            end else begin
                acc_q       <= acc_pk;
                if (out_hs)
                    out_valid_q <= 1'b0;
            end
            if (clr_i)
                word_cnt_q <= '0;
            else if (out_hs)
                word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_iob_dma_axis_packer.sv
// Directed bench for iob_dma_axis_packer (IN_W=8, OUT_W=32) with hand-computed expectations.
module tb_iob_dma_axis_packer;

    logic        clk_i = 1'b0;
    logic        cke_i, rst_n_i, clr_i, flush_i;
    logic [7:0]  in_tdata_i;
    logic        in_tvalid_i, in_tready_o, in_tlast_i;
    logic [31:0] out_tdata_o;
    logic        out_tvalid_o, out_tready_i, out_tlast_o;
    logic [31:0] word_cnt_o;
`ifdef IOB_DMA_PACKER_TKEEP_EN
    logic [3:0]  out_tkeep_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    iob_dma_axis_packer #(.IN_W(8), .OUT_W(32), .CNT_W(32)) dut (
        .clk_i(clk_i), .cke_i(cke_i), .rst_n_i(rst_n_i), .clr_i(clr_i), .flush_i(flush_i),
        .in_tdata_i(in_tdata_i), .in_tvalid_i(in_tvalid_i), .in_tready_o(in_tready_o),
        .in_tlast_i(in_tlast_i), .out_tdata_o(out_tdata_o), .out_tvalid_o(out_tvalid_o),
        .out_tready_i(out_tready_i), .out_tlast_o(out_tlast_o), .word_cnt_o(word_cnt_o)
`ifdef IOB_DMA_PACKER_TKEEP_EN
        , .out_tkeep_o(out_tkeep_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_tdata_i  = d;
        in_tvalid_i = 1'b1;
        in_tlast_i  = last;
        step();
        in_tvalid_i = 1'b0;
        in_tlast_i  = 1'b0;
    endtask

    initial begin
        int idx, acc;
        cke_i = 1; rst_n_i = 0; clr_i = 0; flush_i = 0;
        in_tdata_i = 0; in_tvalid_i = 0; in_tlast_i = 0; out_tready_i = 1;
        step(); step();
        chk("rst_tvalid", out_tvalid_o, 0);
        chk("rst_tdata", out_tdata_o, 0);
        chk("rst_tlast", out_tlast_o, 0);
        chk("rst_cnt", word_cnt_o, 0);
        chk("rst_tready", in_tready_o, 0);
        rst_n_i = 1;
        #1 chk("post_rst_tready", in_tready_o, 1);

        // full word
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        chk("full_no_early_valid", out_tvalid_o, 0);
        send(8'h44, 0);
        chk("full_tvalid", out_tvalid_o, 1);
        chk("full_tdata", out_tdata_o, 32'h44332211);
        chk("full_tlast", out_tlast_o, 0);
`ifdef IOB_DMA_PACKER_TKEEP_EN
        chk("full_tkeep", out_tkeep_o, 4'b1111);
`endif
        step();
        chk("full_drained", out_tvalid_o, 0);
        chk("full_cnt", word_cnt_o, 1);

        // tlast partial word, then next sample back at lane 0
        send(8'hAA, 0); send(8'hBB, 1);
        chk("tlast_tvalid", out_tvalid_o, 1);
        chk("tlast_tdata", out_tdata_o, 32'h0000BBAA);
        chk("tlast_tlast", out_tlast_o, 1);
`ifdef IOB_DMA_PACKER_TKEEP_EN
        chk("tlast_tkeep", out_tkeep_o, 4'b0011);
`endif
        send(8'hCC, 0); send(8'hDD, 0); send(8'hEE, 0); send(8'hFF, 0);
        chk("after_tlast_tdata", out_tdata_o, 32'hFFEEDDCC);
        chk("after_tlast_tlast", out_tlast_o, 0);
        step();
        chk("cnt3", word_cnt_o, 3);

        // backpressure
        clr_i = 1; step(); clr_i = 0;
        chk("clr_cnt", word_cnt_o, 0);
        out_tready_i = 0;
        idx = 1; acc = 0;
        repeat (9) begin
            in_tdata_i  = idx[7:0];
            in_tvalid_i = 1'b1;
            #1;
            if (in_tready_o) acc++;
            step();
            if (acc == idx) idx++;
        end
        chk("bp_accepted", acc, 7);
        chk("bp_tready_low", in_tready_o, 0);
        chk("bp_word1", out_tdata_o, 32'h04030201);
        chk("bp_tvalid", out_tvalid_o, 1);
        out_tready_i = 1;
        #1 chk("bp_tready_release", in_tready_o, 1);
        step();
        in_tvalid_i = 0;
        chk("bp_no_bubble", out_tvalid_o, 1);
        chk("bp_word2", out_tdata_o, 32'h08070605);
        step();
        chk("bp_drained", out_tvalid_o, 0);
        chk("bp_cnt", word_cnt_o, 2);

        // flush
        send(8'h5A, 0);
        flush_i = 1;
        #1 chk("fl_tready_before", in_tready_o, 1);
        step(); flush_i = 0;
        chk("fl_pend_tready", in_tready_o, 0);
        chk("fl_pend_tvalid", out_tvalid_o, 0);
        step();
        chk("fl_tvalid", out_tvalid_o, 1);
        chk("fl_tdata", out_tdata_o, 32'h0000005A);
        chk("fl_tlast", out_tlast_o, 1);
        chk("fl_tready_back", in_tready_o, 1);
`ifdef IOB_DMA_PACKER_TKEEP_EN
        chk("fl_tkeep", out_tkeep_o, 4'b0001);
`endif
        step();
        flush_i = 1; step(); flush_i = 0;
        chk("fl0_tready", in_tready_o, 1);
        step();
        chk("fl0_no_word", out_tvalid_o, 0);
        chk("fl_cnt", word_cnt_o, 3);

        // reset mid-word
        send(8'h11, 0); send(8'h22, 0);
        rst_n_i = 0; step(); rst_n_i = 1;
        chk("rm_tvalid", out_tvalid_o, 0);
        chk("rm_cnt", word_cnt_o, 0);
        send(8'h33, 0); send(8'h44, 0); send(8'h55, 0); send(8'h66, 0);
        chk("rm_tdata", out_tdata_o, 32'h66554433);
        chk("rm_tlast", out_tlast_o, 0);
        step();
        chk("rm_cnt1", word_cnt_o, 1);

        // clock enable freeze, then clear racing an output handshake
        out_tready_i = 0;
        send(8'h77, 0);
        cke_i = 0; in_tdata_i = 8'h88; in_tvalid_i = 1;
        #1 chk("cke_tready", in_tready_o, 0);
        step(); step(); step();
        cke_i = 1; in_tvalid_i = 0;
        send(8'h99, 0); send(8'hAA, 0); send(8'hBB, 0);
        chk("cke_tdata", out_tdata_o, 32'hBBAA9977);
        chk("cke_tvalid_on", out_tvalid_o, 1);
        cke_i = 0;
        #1 chk("cke_tvalid_forced", out_tvalid_o, 0);
        step();
        chk("cke_cnt_frozen", word_cnt_o, 1);
        cke_i = 1; out_tready_i = 1; clr_i = 1;
        step(); clr_i = 0;
        chk("clr_hs_cnt", word_cnt_o, 0);
        chk("clr_hs_drained", out_tvalid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
